// File: rtl/dvs_ravens_pkg.sv
// dvs_ravens_pkg: shared DVS event width, event-server defaults and server state type
package dvs_ravens_pkg;
  localparam int EVENT_BITS = 32;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int NUM_READERS_DEF = 2;
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_RD, DATA} srv_state_t;
  function automatic int ptr_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dvs_rr_arbiter.sv
// dvs_rr_arbiter: combinational round-robin pick, first requester at or after ptr wins
module dvs_rr_arbiter import dvs_ravens_pkg::*; #(
  parameter int N = NUM_READERS_DEF
) (
  input  logic [N-1:0]           req,
  input  logic [ptr_bits(N)-1:0] ptr,
  output logic [N-1:0]           gnt,
  output logic                   valid
);
  localparam int IW = ptr_bits(N);
  logic [IW-1:0] idx;
  // scan from the far end so the closest requester to ptr overwrites last
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/dvs_event_fifo_server.sv
// dvs_event_fifo_server: DVS event queue served one event at a time to round-robin readers
module dvs_event_fifo_server import dvs_ravens_pkg::*; #(
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int NUM_READERS = NUM_READERS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [EVENT_BITS-1:0]        wr_event,
  input  logic [NUM_READERS-1:0]       fifo_req,
  input  logic [NUM_READERS-1:0]       fifo_rd_en,
  output logic [NUM_READERS-1:0]       fifo_grant,
  output logic [EVENT_BITS-1:0]        fifo_event,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [15:0]                  drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = ptr_bits(NUM_READERS);
  logic [EVENT_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [PW-1:0] prio, win_idx;
  logic [NUM_READERS-1:0] arb_gnt, win;
  logic arb_valid, push, pop, start;
  srv_state_t state, state_nx;
  dvs_rr_arbiter #(.N(NUM_READERS)) u_arb (
    .req   (fifo_req),
    .ptr   (prio),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );
  assign fifo_count = count;
  assign fifo_full  = count == (AW+1)'(FIFO_DEPTH);
  assign fifo_empty = count == '0;
  assign push  = wr_en && !fifo_full;
  assign start = state == IDLE && !fifo_empty && arb_valid;
  assign pop   = state == WAIT_RD && |(fifo_rd_en & win);
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE    ? (start ? GRANT : IDLE) :
               state == GRANT   ? WAIT_RD :
               state == WAIT_RD ? (pop ? DATA : IDLE) : IDLE;
  always_comb fifo_grant = state == GRANT ? win : '0;
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_READERS; i++)
      if (arb_gnt[i]) win_idx = PW'(i);
  end
  // a drop is counted on a full write even if a pop frees space at the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      prio       <= '0;
      win        <= '0;
      fifo_event <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        fifo_event <= mem[rd_ptr];
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (wr_en && fifo_full && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (start) begin
        win  <= arb_gnt;
        prio <= win_idx == PW'(NUM_READERS - 1) ? '0 : win_idx + 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_event;
endmodule

// File: tb/tb_dvs_event_fifo_server.sv
// tb_dvs_event_fifo_server: randomized readers/writer against a queue model, scoreboarded monitor
module tb_dvs_event_fifo_server;
  import dvs_ravens_pkg::*;
  localparam int DEPTH = 16;
  localparam int NR = 2;
  logic clk = 0, rst_n = 0, wr_en = 0;
  logic [EVENT_BITS-1:0] wr_event = '0;
  logic [NR-1:0] fifo_req = '0, fifo_rd_en = '0, fifo_grant;
  logic [EVENT_BITS-1:0] fifo_event;
  logic fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0] drop_count;
  always #5 clk = ~clk;
  dvs_event_fifo_server #(.FIFO_DEPTH(DEPTH), .NUM_READERS(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_event   (wr_event),
    .fifo_req   (fifo_req),
    .fifo_rd_en (fifo_rd_en),
    .fifo_grant (fifo_grant),
    .fifo_event (fifo_event),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .drop_count (drop_count)
  );
  int passed = 0, total = 0, grant_cnt = 0, drops = 0, rst_cycles = 2;
  int p_wr = 0, p_req = 0, p_rd = 100;
  logic [NR-1:0] req_mask = '0;
  logic [EVENT_BITS-1:0] ref_q[$], sb[$], wr_list[$];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // driver: applies the edge just taken to the queue model, then drives the next cycle
  initial begin : driver
    logic [NR-1:0] gprev;
    bit pop_pend, acc;
    gprev = '0;
    pop_pend = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ref_q.delete();
        sb.delete();
        drops = 0;
      end else begin
        acc = ref_q.size() < DEPTH;
        if (pop_pend) begin
          check("pop_nonempty", ref_q.size() > 0, 1);
          if (ref_q.size() > 0) sb.push_back(ref_q.pop_front());
        end
        if (wr_en && acc) ref_q.push_back(wr_event);
        else if (wr_en && drops < 65535) drops++;
      end
      rst_n = rst_cycles == 0;
      if (rst_cycles > 0) rst_cycles--;
      for (int r = 0; r < NR; r++) begin
        fifo_rd_en[r] = gprev[r] ? ($urandom_range(99) < p_rd) : ($urandom_range(99) < 5);
        if (!req_mask[r] || fifo_grant[r]) fifo_req[r] = 1'b0;
        else if ($urandom_range(99) < p_req) fifo_req[r] = 1'b1;
      end
      pop_pend = |(gprev & fifo_rd_en);
      gprev = fifo_grant & {NR{rst_n}};
      if (wr_list.size() > 0) begin
        wr_en = 1'b1;
        wr_event = wr_list.pop_front();
      end else begin
        wr_en = rst_n && ($urandom_range(99) < p_wr);
        wr_event = $urandom;
      end
    end
  end
  // monitor: observes the bus at negedge, checks flags, arbitration and delivered events
  initial begin : monitor
    logic [NR-1:0] prev_req, gw, exp_g;
    int prev_cnt, ptr, c;
    bit prev_rst, due;
    prev_req = '0; gw = '0; prev_cnt = 0; ptr = 0; prev_rst = 1; due = 0;
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        check("rst_grant", fifo_grant, 0);
        check("rst_count", fifo_count, 0);
        check("rst_event", fifo_event, 0);
        check("rst_drop", drop_count, 0);
        check("rst_flags", {fifo_full, fifo_empty}, 2'b01);
        ptr = 0; gw = '0; due = 0;
      end else begin
        check("count", fifo_count, ref_q.size());
        check("full", fifo_full, ref_q.size() == DEPTH);
        check("empty", fifo_empty, ref_q.size() == 0);
        check("drop", drop_count, drops);
        if (due) begin
          check("event_expected", sb.size() != 0, 1);
          if (sb.size() != 0) check("event", fifo_event, sb.pop_front());
          due = 0;
        end
        if (gw != '0) begin
          due = |(gw & fifo_rd_en);
          gw = '0;
        end
        if (fifo_grant != '0) begin
          grant_cnt++;
          check("grant_nonempty", prev_cnt > 0, 1);
          exp_g = '0;
          for (int k = 0; k < NR; k++) begin
            c = (ptr + k) % NR;
            if (prev_req[c]) begin
              exp_g[c] = 1'b1;
              ptr = (c + 1) % NR;
              break;
            end
          end
          check("rr_grant", fifo_grant, exp_g);
          gw = fifo_grant;
        end
      end
      prev_req = fifo_req;
      prev_cnt = ref_q.size();
      prev_rst = !rst_n;
    end
  end
  initial begin : main
    int g0;
    bit got;
    repeat (4) @(posedge clk);
    wr_list = '{32'h1, 32'h2, 32'h3};
    repeat (5) @(posedge clk);
    req_mask = 2'b01; p_req = 100;
    repeat (20) @(posedge clk);
    req_mask = '0;
    repeat (6) @(posedge clk);
    rst_cycles = 1;
    repeat (3) @(posedge clk);
    for (int i = 0; i <= DEPTH; i++) wr_list.push_back(32'h100 + i);
    repeat (DEPTH + 4) @(posedge clk);
    req_mask = '1;
    repeat (DEPTH * 4 + 10) @(posedge clk);
    req_mask = 2'b01; p_rd = 0; wr_list = '{32'hA5, 32'hA6};
    repeat (20) @(posedge clk);
    p_rd = 100;
    repeat (20) @(posedge clk);
    req_mask = '1; g0 = grant_cnt;
    repeat (20) @(posedge clk);
    check("no_grant_empty", grant_cnt - g0, 0);
    req_mask = 2'b01; wr_list = '{32'h7, 32'h8, 32'h9};
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = fifo_grant[0];
    end
    check("grant_seen", got, 1);
    rst_cycles = 1;
    repeat (4) @(posedge clk);
    req_mask = '1; p_wr = 40; p_req = 50; p_rd = 85;
    repeat (1500) @(posedge clk);
    rst_cycles = 1;
    repeat (1500) @(posedge clk);
    p_wr = 0; p_rd = 100;
    repeat (200) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
